// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter slice.
package mem_arb_pkg;

  // Default number of 32-bit words in one cache line.
  localparam int LINE_WORDS_DEF = 8;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Grant encoding shared by the round-robin picker and the burst owner latch.
  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker. The last_grant register only advances on
// the update strobe, so it reflects the owner of the most recent burst.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_ic,
  input  logic req_dc,
  input  logic update,
  output logic gnt
);

  logic last_grant_r;
  logic pick_s;

  // Pick the sole requester, or on a tie the one not granted last time.
  always_comb begin
    pick_s = GNT_IC;
    if (req_ic && req_dc) begin
      pick_s = ~last_grant_r;
    end else if (req_dc) begin
      pick_s = GNT_DC;
    end else begin
      pick_s = GNT_IC;
    end
  end

  // Remember the winner when a burst is started; reset favours DCache on the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_r <= GNT_IC;
    end else if (update) begin
      last_grant_r <= pick_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  assign gnt = pick_s;

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter: serves ICache line refills and DCache line
// refills/write-backs as LINE_WORDS-beat bursts of 32-bit words.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int ADDR_W     = 32,
  parameter int WIDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  // ICache miss engine
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [31:0]       ic_rdata,
  output logic              ic_rvalid,
  output logic [WIDX_W-1:0] ic_word,
  output logic              ic_done,
  // DCache miss engine
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [31:0]       dc_wdata,
  output logic [31:0]       dc_rdata,
  output logic              dc_rvalid,
  output logic [WIDX_W-1:0] dc_word,
  output logic              dc_done,
  // Main memory
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  // Byte-offset bits within a line: word index plus the 2-bit byte lane.
  localparam int                OFS_W    = WIDX_W + 2;
  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(LINE_WORDS - 1);

  arb_state_e         state_r;
  logic               owner_r;
  logic               we_r;
  logic [ADDR_W-1:0]  base_r;
  logic [WIDX_W-1:0]  cnt_r;
  logic               mem_req_r;
  logic               mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [31:0]        ic_rdata_r;
  logic               ic_rvalid_r;
  logic [WIDX_W-1:0]  ic_word_r;
  logic               ic_done_r;
  logic [31:0]        dc_rdata_r;
  logic               dc_rvalid_r;
  logic [WIDX_W-1:0]  dc_word_r;
  logic               dc_done_r;
  logic [31:0]        busy_cnt_r;

  logic               any_req_s;
  logic               gnt_s;
  logic               grant_now_s;
  logic [ADDR_W-1:0]  sel_base_s;
  logic               sel_we_s;
  logic [WIDX_W-1:0]  cnt_inc_s;
  logic               last_beat_s;
  logic               dc_wr_beat_s;
  logic               unused_s;

  assign any_req_s   = ic_req | dc_req;
  assign grant_now_s = (state_r == IDLE) && any_req_s;
  assign cnt_inc_s   = cnt_r + WIDX_W'(1);
  assign last_beat_s = (cnt_r == LAST_IDX);

  // Low address bits select bytes within the line and are dropped.
  assign unused_s = ^{ic_addr[OFS_W-1:0], dc_addr[OFS_W-1:0]};

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_ic (ic_req),
    .req_dc (dc_req),
    .update (grant_now_s),
    .gnt    (gnt_s)
  );

  // Line base address and direction of whichever requester the picker chose.
  always_comb begin
    sel_base_s = '0;
    sel_we_s   = 1'b0;
    if (gnt_s == GNT_DC) begin
      sel_base_s = {dc_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      sel_we_s   = dc_we;
    end else begin
      sel_base_s = {ic_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      sel_we_s   = 1'b0;
    end
  end

  // Burst sequencer: grant, beat counting, read return and done pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      owner_r     <= GNT_IC;
      we_r        <= 1'b0;
      base_r      <= '0;
      cnt_r       <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      ic_rdata_r  <= 32'd0;
      ic_rvalid_r <= 1'b0;
      ic_word_r   <= '0;
      ic_done_r   <= 1'b0;
      dc_rdata_r  <= 32'd0;
      dc_rvalid_r <= 1'b0;
      dc_word_r   <= '0;
      dc_done_r   <= 1'b0;
    end else begin
      // Strobes and word indices are single-cycle unless re-armed below.
      ic_rvalid_r <= 1'b0;
      ic_word_r   <= '0;
      ic_done_r   <= 1'b0;
      dc_rvalid_r <= 1'b0;
      dc_word_r   <= '0;
      dc_done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r    <= gnt_s;
            we_r       <= sel_we_s;
            base_r     <= sel_base_s;
            cnt_r      <= '0;
            mem_req_r  <= 1'b1;
            mem_we_r   <= sel_we_s;
            mem_addr_r <= sel_base_s;
            state_r    <= XFER;
          end else begin
            state_r    <= IDLE;
          end
        end
        XFER: begin
          if (mem_ready) begin
            if (!we_r) begin
              if (owner_r == GNT_DC) begin
                dc_rdata_r  <= mem_rdata;
                dc_rvalid_r <= 1'b1;
                dc_word_r   <= cnt_r;
              end else begin
                ic_rdata_r  <= mem_rdata;
                ic_rvalid_r <= 1'b1;
                ic_word_r   <= cnt_r;
              end
            end else begin
              we_r <= we_r;
            end
            if (last_beat_s) begin
              state_r    <= DONE;
              cnt_r      <= '0;
              mem_req_r  <= 1'b0;
              mem_we_r   <= 1'b0;
              mem_addr_r <= '0;
              if (owner_r == GNT_DC) begin
                dc_done_r <= 1'b1;
              end else begin
                ic_done_r <= 1'b1;
              end
            end else begin
              cnt_r      <= cnt_inc_s;
              mem_addr_r <= {base_r[ADDR_W-1:OFS_W], cnt_inc_s, 2'b00};
            end
          end else begin
            state_r <= XFER;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          cnt_r      <= '0;
          mem_req_r  <= 1'b0;
          mem_we_r   <= 1'b0;
          mem_addr_r <= '0;
        end
      endcase
    end
  end

  // Count every cycle the memory port is occupied; wraps silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_cnt_r <= 32'd0;
    end else if (mem_req_r) begin
      busy_cnt_r <= busy_cnt_r + 32'd1;
    end else begin
      busy_cnt_r <= busy_cnt_r;
    end
  end

  // During a write-back the DCache sees the live beat index so it can
  // drive the matching word in the same cycle.
  assign dc_wr_beat_s = (state_r == XFER) && (owner_r == GNT_DC) && we_r;

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = (mem_req_r && mem_we_r) ? dc_wdata : 32'd0;
  assign ic_rdata  = ic_rdata_r;
  assign ic_rvalid = ic_rvalid_r;
  assign ic_word   = ic_word_r;
  assign ic_done   = ic_done_r;
  assign dc_rdata  = dc_rdata_r;
  assign dc_rvalid = dc_rvalid_r;
  assign dc_word   = dc_wr_beat_s ? cnt_r : dc_word_r;
  assign dc_done   = dc_done_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an ideal memory (data = address) and a
// DCache that returns 0xA0 + word index for write-backs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = 32'd0;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic [2:0]  ic_word;
  logic        ic_done;
  logic        dc_req = 1'b0;
  logic        dc_we = 1'b0;
  logic [31:0] dc_addr = 32'd0;
  logic [31:0] dc_wdata;
  logic [31:0] dc_rdata;
  logic        dc_rvalid;
  logic [2:0]  dc_word;
  logic        dc_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  assign mem_rdata = mem_addr;
  assign dc_wdata  = 32'hA0 + {29'd0, dc_word};

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_rvalid (ic_rvalid),
    .ic_word   (ic_word),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_rdata  (dc_rdata),
    .dc_rvalid (dc_rvalid),
    .dc_word   (dc_word),
    .dc_done   (dc_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Wait for the next done pulse; reports owner (0=IC, 1=DC, -1=timeout) and first beat address.
  task automatic wait_done(output int who, output logic [31:0] first_addr);
    logic seen;
    who = -1;
    first_addr = 32'd0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && !seen) begin
        first_addr = mem_addr;
        seen = 1'b1;
      end
      if (ic_done === 1'b1) begin
        who = 0;
        break;
      end
      if (dc_done === 1'b1) begin
        who = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0)
      begin failures++; $display("FAIL reset_mem got=%h/%h/%h/%h exp=0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++;
    if ({ic_rdata, ic_rvalid, ic_word, ic_done} !== 37'd0)
      begin failures++; $display("FAIL reset_ic got=%h/%h/%h/%h exp=0", ic_rdata, ic_rvalid, ic_word, ic_done); end
    checks++;
    if ({dc_rdata, dc_rvalid, dc_word, dc_done} !== 37'd0)
      begin failures++; $display("FAIL reset_dc got=%h/%h/%h/%h exp=0", dc_rdata, dc_rvalid, dc_word, dc_done); end
    rst = 1'b1;
    mem_ready = 1'b0;
  endtask

  task automatic test_ic_read();
    int k, rv;
    logic seen_done;
    logic [31:0] busy0;
    k = 0; rv = 0; seen_done = 1'b0;
    @(negedge clk);
    busy0 = dut.busy_cnt_r;
    ic_addr = 32'h1234; ic_req = 1'b1; mem_ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        checks++;
        if (mem_addr !== 32'h1220 + 32'(4 * k) || mem_we !== 1'b0)
          begin failures++; $display("FAIL ic_beat k=%0d got=%h we=%b exp=%h", k, mem_addr, mem_we, 32'h1220 + 32'(4 * k)); end
        k++;
      end
      if (ic_rvalid === 1'b1) begin
        checks++;
        if (ic_word !== 3'(rv) || ic_rdata !== 32'h1220 + 32'(4 * rv))
          begin failures++; $display("FAIL ic_rdata n=%0d got=%0d/%h exp=%0d/%h", rv, ic_word, ic_rdata, rv, 32'h1220 + 32'(4 * rv)); end
        rv++;
      end
      checks++;
      if (dc_rvalid !== 1'b0 || dc_done !== 1'b0)
        begin failures++; $display("FAIL ic_dc_quiet got=%b%b exp=00", dc_rvalid, dc_done); end
      if (ic_done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (rv != 8 || ic_rvalid !== 1'b1 || ic_word !== 3'd7)
          begin failures++; $display("FAIL ic_done_word got=%0d/%b/%0d exp=8/1/7", rv, ic_rvalid, ic_word); end
        // Request cycle, 8 beats, done: done seen 9 negedges after asserting req.
        checks++;
        if (cyc != 9)
          begin failures++; $display("FAIL ic_latency got=%0d exp=9", cyc); end
        ic_req = 1'b0;
        break;
      end
    end
    checks++;
    if (!seen_done || k != 8)
      begin failures++; $display("FAIL ic_complete got=%b/%0d exp=1/8", seen_done, k); end
    checks++;
    if (dut.busy_cnt_r - busy0 !== 32'd8)
      begin failures++; $display("FAIL busy_cnt got=%0d exp=8", dut.busy_cnt_r - busy0); end
  endtask

  task automatic test_dc_write();
    int k, last_cyc;
    logic seen_done;
    k = 0; last_cyc = 0; seen_done = 1'b0;
    @(negedge clk);
    dc_addr = 32'h80; dc_we = 1'b1; dc_req = 1'b1; mem_ready = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h80 + 32'(4 * k) ||
            mem_wdata !== 32'hA0 + 32'(k) || dc_word !== 3'(k))
          begin failures++; $display("FAIL dc_wr_beat k=%0d got=%b/%h/%h/%0d exp=1/%h/%h/%0d",
                                     k, mem_we, mem_addr, mem_wdata, dc_word, 32'h80 + 32'(4 * k), 32'hA0 + 32'(k), k); end
        k++;
        last_cyc = cyc;
      end
      checks++;
      if (dc_rvalid !== 1'b0 || ic_rvalid !== 1'b0 || ic_done !== 1'b0)
        begin failures++; $display("FAIL dc_wr_quiet got=%b%b%b exp=000", dc_rvalid, ic_rvalid, ic_done); end
      if (dc_done === 1'b1) begin
        seen_done = 1'b1;
        checks++;
        if (k != 8 || cyc != last_cyc + 1)
          begin failures++; $display("FAIL dc_wr_done got=%0d/%0d exp=8/%0d", k, cyc, last_cyc + 1); end
        dc_req = 1'b0; dc_we = 1'b0;
        break;
      end
    end
    checks++;
    if (!seen_done)
      begin failures++; $display("FAIL dc_wr_timeout got=0 exp=1"); end
  endtask

  task automatic test_round_robin();
    int who;
    logic [31:0] fa;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ic_addr = 32'h100; dc_addr = 32'h200; dc_we = 1'b0; mem_ready = 1'b1;
    ic_req = 1'b1; dc_req = 1'b1;
    wait_done(who, fa);
    checks++;
    if (who != 1 || fa !== 32'h200)
      begin failures++; $display("FAIL rr_first got=%0d/%h exp=1/00000200", who, fa); end
    dc_req = 1'b0;
    wait_done(who, fa);
    checks++;
    if (who != 0 || fa !== 32'h100)
      begin failures++; $display("FAIL rr_second got=%0d/%h exp=0/00000100", who, fa); end
    // Both raised again while the ICache burst is in DONE.
    dc_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0)
      begin failures++; $display("FAIL rr_idle_gap got=%b exp=0", mem_req); end
    wait_done(who, fa);
    checks++;
    if (who != 1 || fa !== 32'h200)
      begin failures++; $display("FAIL rr_third got=%0d/%h exp=1/00000200", who, fa); end
    ic_req = 1'b0; dc_req = 1'b0;
  endtask

  task automatic test_wait_states();
    logic [3:0] pat;
    logic drive, seen_done;
    int p, k, rv;
    pat = 4'b1001;
    p = 0; k = 0; rv = 0; seen_done = 1'b0;
    @(negedge clk);
    ic_addr = 32'h400; ic_req = 1'b1;
    mem_ready = pat[p % 4]; p++;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        checks++;
        if (mem_addr !== 32'h400 + 32'(4 * k))
          begin failures++; $display("FAIL ws_addr k=%0d got=%h exp=%h", k, mem_addr, 32'h400 + 32'(4 * k)); end
      end
      if (ic_rvalid === 1'b1) begin
        checks++;
        if (ic_word !== 3'(rv))
          begin failures++; $display("FAIL ws_word got=%0d exp=%0d", ic_word, rv); end
        rv++;
      end
      if (ic_done === 1'b1) begin
        seen_done = 1'b1;
        break;
      end
      drive = pat[p % 4]; p++;
      mem_ready = drive;
      if (mem_req === 1'b1 && drive) k++;
    end
    checks++;
    if (!seen_done || k != 8 || rv != 8)
      begin failures++; $display("FAIL ws_complete got=%b/%0d/%0d exp=1/8/8", seen_done, k, rv); end
    ic_req = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    int who, dones;
    logic found;
    logic [31:0] fa;
    found = 1'b0; dones = 0;
    @(negedge clk);
    dc_addr = 32'h300; dc_we = 1'b0; dc_req = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1 && mem_addr === 32'h30C) begin
        found = 1'b1;
        rst = 1'b0;
        break;
      end
    end
    checks++;
    if (!found)
      begin failures++; $display("FAIL rst_beat3 got=0 exp=1"); end
    @(negedge clk);
    rst = 1'b1; dc_req = 1'b0;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0)
      begin failures++; $display("FAIL rst_mid_mem got=%h/%h/%h/%h exp=0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++;
    if ({dc_rdata, dc_rvalid, dc_word, dc_done, ic_rvalid, ic_done} !== 39'd0)
      begin failures++; $display("FAIL rst_mid_dc got=%h/%h/%h/%h exp=0", dc_rdata, dc_rvalid, dc_word, dc_done); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (dc_done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0)
      begin failures++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
    ic_addr = 32'h500; ic_req = 1'b1;
    wait_done(who, fa);
    checks++;
    if (who != 0 || fa !== 32'h500)
      begin failures++; $display("FAIL rst_regrant got=%0d/%h exp=0/00000500", who, fa); end
    ic_req = 1'b0;
  endtask

  task automatic test_drop_req();
    int k, rv, dn;
    logic [2:0] last_word;
    k = 0; rv = 0; dn = 0; last_word = 3'd0;
    @(negedge clk);
    ic_addr = 32'h600; ic_req = 1'b1; mem_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        checks++;
        if (mem_addr !== 32'h600 + 32'(4 * k))
          begin failures++; $display("FAIL drop_addr k=%0d got=%h exp=%h", k, mem_addr, 32'h600 + 32'(4 * k)); end
        if (k == 2) begin
          ic_req = 1'b0;
          ic_addr = 32'hFFFF0000;
        end
        k++;
      end
      if (ic_rvalid === 1'b1) begin
        rv++;
        last_word = ic_word;
      end
      if (ic_done === 1'b1) dn++;
    end
    checks++;
    if (k != 8 || rv != 8 || dn != 1 || last_word !== 3'd7)
      begin failures++; $display("FAIL drop_complete got=%0d/%0d/%0d/%0d exp=8/8/1/7", k, rv, dn, last_word); end
  endtask

  initial begin
    test_reset();
    test_ic_read();
    test_dc_write();
    test_round_robin();
    test_wait_states();
    test_reset_mid_burst();
    test_drop_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
